// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles every signal exchanged between the hazard controller and the
// pipeline around it.
//
// Signals driven towards the controller (master -> slave):
//   id_rs_i, id_rt_i   source register fields of the instruction in ID
//   id_uses_rt_i       ID instruction reads rt as a source
//   ex_memread_i       instruction in EX is a load
//   ex_rd_i            destination register of the instruction in EX
//   branch_taken_i     branch in MEM resolved taken this cycle
//   mem_busy_i         data memory not ready, the pipe must hold
// Signals driven by the controller (slave -> master):
//   pc_write_o, ifid_write_o, pipe_en_o              write enables
//   ifid_flush_o, idex_flush_o, exmem_flush_o        clear-to-NOP controls
//   state_o                                          0 RUN, 1 BUSY, 2 BUSY_BR
//   stall_cnt_o, flush_cnt_o                         saturating counters
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_uses_rt_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rd_i;
   logic             branch_taken_i;
   logic             mem_busy_i;

   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             exmem_flush_o;
   logic             pipe_en_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   // The pipeline side supplies decode/hazard information and consumes
   // the enables.
   modport master (
      output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             branch_taken_i, mem_busy_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
             exmem_flush_o, pipe_en_o, state_o, stall_cnt_o, flush_cnt_o
   );

   // The hazard controller itself.
   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             branch_taken_i, mem_busy_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
             exmem_flush_o, pipe_en_o, state_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard controller for the 5-stage MIPS pipeline. Chooses one of
// four actions every cycle (NORMAL, FREEZE, FLUSH, BUBBLE) and drives the
// PC / IF/ID / downstream pipeline register enables and flushes from it.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     pipe_hazard_ctrl_if.slave, all hazard inputs and control outputs
// Parameter:
//   CNT_W   width of the saturating stall and flush counters; must match
//           the CNT_W of the connected interface instance
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BUSY    = 2'd1,
      ST_BUSY_BR = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   logic   w_hz;
   logic   w_freeze;
   logic   w_flush;
   logic   w_bubble;
   state_t w_nextState;

   // Load-use hazard: a load in EX writes a register that the ID
   // instruction reads. Register 0 never carries a dependency.
   assign w_hz = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                 ((bus.ex_rd_i == bus.id_rs_i) ||
                  (bus.id_uses_rt_i && (bus.ex_rd_i == bus.id_rt_i)));

   // Action selection. Memory busy dominates everything; a branch pending
   // from a freeze behaves like a branch taken this cycle, so BUSY_BR
   // flushes as soon as memory is ready. BUSY without busy is identical
   // to RUN, and the unused encoding falls back to RUN behaviour too.
   always_comb begin
      w_freeze    = 1'b0;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      w_nextState = ST_RUN;
      if (bus.mem_busy_i) begin
         w_freeze    = 1'b1;
         w_nextState = ((r_state == ST_BUSY_BR) || bus.branch_taken_i) ?
                       ST_BUSY_BR : ST_BUSY;
      end else if ((r_state == ST_BUSY_BR) || bus.branch_taken_i) begin
         w_flush = 1'b1;
      end else if (w_hz) begin
         w_bubble = 1'b1;
      end
   end

   // Enables and flushes follow the chosen action combinationally; they
   // are all forced low while reset is asserted.
   always_comb begin
      bus.pc_write_o    = rst_i && !(w_freeze || w_bubble);
      bus.ifid_write_o  = rst_i && !(w_freeze || w_bubble);
      bus.pipe_en_o     = rst_i && !w_freeze;
      bus.ifid_flush_o  = rst_i && w_flush;
      bus.idex_flush_o  = rst_i && (w_flush || w_bubble);
      bus.exmem_flush_o = rst_i && w_flush;
   end

   // State register plus the two saturating performance counters. Reset
   // also drops any branch waiting in BUSY_BR.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= ST_RUN;
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         r_state <= w_nextState;
         if ((w_freeze || w_bubble) && (r_stallCnt != CNT_MAX))
            r_stallCnt <= r_stallCnt + CNT_ONE;
         if (w_flush && (r_flushCnt != CNT_MAX))
            r_flushCnt <= r_flushCnt + CNT_ONE;
      end
   end

   assign bus.state_o     = r_state;
   assign bus.stall_cnt_o = r_stallCnt;
   assign bus.flush_cnt_o = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives two controllers (16-bit and 4-bit counters) with identical inputs
// and compares them each cycle against a reference model that keeps only
// "a branch is pending" and "the previous cycle was frozen" flags plus
// unbounded counters, saturated at comparison time.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int ACT_NORMAL = 0;
   localparam int ACT_FREEZE = 1;
   localparam int ACT_FLUSH  = 2;
   localparam int ACT_BUBBLE = 3;

   logic clk;
   logic rst_n;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

   pipe_hazard_ctrl #(.CNT_W(16)) dut16 (.clk_i(clk), .rst_i(rst_n), .bus(bus16));
   pipe_hazard_ctrl #(.CNT_W(4))  dut4  (.clk_i(clk), .rst_i(rst_n), .bus(bus4));

   int totalCount = 0;
   int passCount  = 0;

   bit mPending;
   bit mFrozen;
   int mStall;
   int mFlush;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a failure with both values.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] check %s failed", tag);
      end
   endtask

   // Puts the same input values on both interfaces.
   task automatic driveInputs(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                              input logic memRead, input logic [4:0] rd,
                              input logic br, input logic busy);
      bus16.id_rs_i = rs;         bus4.id_rs_i = rs;
      bus16.id_rt_i = rt;         bus4.id_rt_i = rt;
      bus16.id_uses_rt_i = usesRt; bus4.id_uses_rt_i = usesRt;
      bus16.ex_memread_i = memRead; bus4.ex_memread_i = memRead;
      bus16.ex_rd_i = rd;         bus4.ex_rd_i = rd;
      bus16.branch_taken_i = br;  bus4.branch_taken_i = br;
      bus16.mem_busy_i = busy;    bus4.mem_busy_i = busy;
   endtask

   function automatic logic [5:0] actionBits(input int act);
      // {pc_write, ifid_write, pipe_en, ifid_flush, idex_flush, exmem_flush}
      case (act)
         ACT_FREEZE: return 6'b000_000;
         ACT_FLUSH:  return 6'b111_111;
         ACT_BUBBLE: return 6'b001_010;
         default:    return 6'b111_000;
      endcase
   endfunction

   function automatic int sat(input int v, input int maxV);
      return (v > maxV) ? maxV : v;
   endfunction

   // One pipeline cycle: apply inputs after the falling edge, check all
   // outputs a little later, then advance the model past the rising edge.
   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                input logic memRead, input logic [4:0] rd,
                                input logic br, input logic busy);
      bit hz;
      int act;
      int expState;
      @(negedge clk);
      driveInputs(rs, rt, usesRt, memRead, rd, br, busy);
      #1;
      hz = memRead && (rd != 0) && ((rd == rs) || (usesRt && (rd == rt)));
      if (busy)                 act = ACT_FREEZE;
      else if (mPending || br)  act = ACT_FLUSH;
      else if (hz)              act = ACT_BUBBLE;
      else                      act = ACT_NORMAL;
      expState = mPending ? 2 : (mFrozen ? 1 : 0);

      checkOutput("out16", {26'd0, bus16.pc_write_o, bus16.ifid_write_o, bus16.pipe_en_o,
                  bus16.ifid_flush_o, bus16.idex_flush_o, bus16.exmem_flush_o},
                  {26'd0, actionBits(act)});
      checkOutput("out4", {26'd0, bus4.pc_write_o, bus4.ifid_write_o, bus4.pipe_en_o,
                  bus4.ifid_flush_o, bus4.idex_flush_o, bus4.exmem_flush_o},
                  {26'd0, actionBits(act)});
      checkOutput("state16", {30'd0, bus16.state_o}, expState);
      checkOutput("state4",  {30'd0, bus4.state_o},  expState);
      checkOutput("stall16", {16'd0, bus16.stall_cnt_o}, sat(mStall, 65535));
      checkOutput("flush16", {16'd0, bus16.flush_cnt_o}, sat(mFlush, 65535));
      checkOutput("stall4",  {28'd0, bus4.stall_cnt_o},  sat(mStall, 15));
      checkOutput("flush4",  {28'd0, bus4.flush_cnt_o},  sat(mFlush, 15));

      if (act == ACT_FREEZE || act == ACT_BUBBLE) mStall++;
      if (act == ACT_FLUSH) mFlush++;
      if (busy) begin
         mPending = mPending || br;
         mFrozen  = 1'b1;
      end else begin
         mPending = 1'b0;
         mFrozen  = 1'b0;
      end
   endtask

   // Holds reset low for one rising edge with the current inputs left in
   // place, checks the reset outputs, then releases with idle inputs.
   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_out16", {26'd0, bus16.pc_write_o, bus16.ifid_write_o, bus16.pipe_en_o,
                  bus16.ifid_flush_o, bus16.idex_flush_o, bus16.exmem_flush_o}, 32'd0);
      checkOutput("rst_state16", {30'd0, bus16.state_o}, 32'd0);
      checkOutput("rst_stall16", {16'd0, bus16.stall_cnt_o}, 32'd0);
      checkOutput("rst_flush16", {16'd0, bus16.flush_cnt_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      driveInputs(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      mPending = 1'b0;
      mFrozen  = 1'b0;
      mStall   = 0;
      mFlush   = 0;
   endtask

   initial begin
      rst_n = 1'b1;
      driveInputs(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      mPending = 1'b0;
      mFrozen  = 1'b0;
      mStall   = 0;
      mFlush   = 0;
      applyReset();

      // lw $t0 in EX, add using $t0 in ID: one bubble, then normal flow.
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("tp_lwuse_stall", {16'd0, bus16.stall_cnt_o}, 32'd1);

      // Register 0 never hazards; rt match ignored when rt is not read.
      applyReset();
      applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      applyStimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      applyStimulus(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);

      // Branch and load-use in the same cycle: flush wins, no stall.
      applyReset();
      applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("tp_brhz_flush", {16'd0, bus16.flush_cnt_o}, 32'd1);
      checkOutput("tp_brhz_stall", {16'd0, bus16.stall_cnt_o}, 32'd0);

      // Three busy cycles with a branch in the second: deferred flush.
      applyReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("tp_defer_stall", {16'd0, bus16.stall_cnt_o}, 32'd3);
      checkOutput("tp_defer_flush", {16'd0, bus16.flush_cnt_o}, 32'd1);

      // Long freeze: the 4-bit counter saturates at 15.
      applyReset();
      for (int i = 0; i < 20; i++)
         applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("tp_sat_stall4", {28'd0, bus4.stall_cnt_o}, 32'd15);
      checkOutput("tp_sat_stall16", {16'd0, bus16.stall_cnt_o}, 32'd20);

      // Reset while a branch is pending discards it.
      applyReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      checkOutput("tp_busybr_state", {30'd0, bus16.state_o}, 32'd1);
      applyReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("tp_rst_noflush", {16'd0, bus16.flush_cnt_o}, 32'd0);

      // Randomised traffic with small register numbers so hazards are common.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 63) == 0) applyReset();
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
